booth_radix4_seq_mult: RTL
==========================

Name: booth_radix4_seq_mult

Overview:
Iterative radix-4 Booth multiplier, parametrised in operand width. It retires one recoded digit per clock and supports both signed and unsigned operands, selected per operation. It replaces the combinational per-digit encoder in the datapath. Operands and results move over valid/ready handshakes, so the block sits between an operand issue stage and a writeback stage.

Parameters:
- WIDTH, 32, operand width in bits; must be even and at least 4.
- ITER, WIDTH/2+1, digits per operation; derived, not overridable.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operand pair valid.
- in_ready, output, 1, block can accept operands.
- a, input, WIDTH, multiplicand.
- b, input, WIDTH, multiplier (the Booth-recoded operand).
- signed_mode, input, 1, 1 = both operands two's complement; 0 = both unsigned.
- out_valid, output, 1, product valid.
- out_ready, input, 1, consumer accepts the product.
- p, output, 2*WIDTH, product.
- busy, output, 1, high in RUN and DONE.

Behaviour:
- Reset (asynchronous, rst_n low): state = IDLE, in_ready = 1, out_valid = 0, busy = 0, p = 0, digit counter = 0.
- State IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at a rising edge: latch a, b and signed_mode.
  - Extend both operands to WIDTH+2 bits: sign-extend when signed_mode = 1, zero-extend when 0.
  - Clear the accumulator and the implicit b[-1] bit; go to RUN.
- State RUN:
  - in_ready = 0.
  - Each cycle, recode triplet {b[2i+1], b[2i], b[2i-1]} to a digit: 000/111 -> 0; 001/010 -> +A; 011 -> +2A; 100 -> -2A; 101/110 -> -A.
  - Add the selected partial product, sign-extended to the full accumulator width and weighted by 4^i, to the accumulator. Two's-complement negation is ~x+1; no saturation.
  - After digit ITER-1, go to DONE with out_valid = 1.
- Latency: operands accepted at edge k; out_valid is high after edge k+ITER (17 cycles at WIDTH=32).
- State DONE:
  - p holds the low 2*WIDTH bits of the exact product; this is exact for both modes.
  - p and out_valid stay stable until out_ready = 1 at an edge, then the block returns to IDLE with out_valid = 0.
  - p holds its last value after the handshake; it is not cleared.
- Handshake rules:
  - in_ready is high only in IDLE, so no new operation is accepted in the same cycle as the output handshake.
  - a, b and signed_mode are ignored outside the accept edge.
  - out_ready is ignored while out_valid = 0.
- Boundaries:
  - Most-negative operands (e.g. 0x80000000 x 0x80000000 signed) must not overflow internally; the accumulator is at least 2*WIDTH+4 bits.
  - Zero operands still take the full ITER cycles unless the optional feature is enabled.
- Reset mid-operation: the in-flight operation is abandoned silently and the reset values above apply.
- busy = (state != IDLE).

Optional Feature:
- Macro: BOOTH_EARLY_TERM_EN.
- Defined: after each digit in RUN, if every remaining unprocessed multiplier bit, including the current b[2i+1], is equal (all 0 or all 1), all remaining digits are 0. The block then goes straight to DONE at that edge, so latency varies from 1 to ITER. If the first check already passes, as for b = 0, latency is 1.
- Not defined: fixed latency of ITER; the block contains no early-termination logic.

Test Plan:
- Signed mode, a = -3, b = 7 -> p = 64'hFFFF_FFFF_FFFF_FFEB; out_valid first high 17 cycles after accept.
- Unsigned mode, a = b = 32'hFFFF_FFFF -> p = 64'hFFFF_FFFE_0000_0001; signed mode, same operands -> p = 64'h1.
- Signed mode, a = b = 32'h8000_0000 -> p = 64'h4000_0000_0000_0000; unsigned mode, same operands -> p = 64'h4000_0000_0000_0000.
- Backpressure: out_ready held 0 for 10 cycles after out_valid -> p and out_valid stable, in_ready = 0 throughout. Then out_ready = 1 for one cycle -> IDLE, in_ready = 1 on the next cycle.
- rst_n pulsed low at RUN cycle 5 -> outputs immediately at reset values. A new op after release (a = 5, b = 3, unsigned) -> p = 15 with full latency.
- With BOOTH_EARLY_TERM_EN: a = 5, b = 3 -> p = 15 with out_valid 2 cycles after accept; b = 0 -> p = 0 after 1 cycle.

Source files
------------

// File: rtl/booth_radix4_seq_mult.sv
// booth_radix4_seq_mult
//   Iterative radix-4 Booth multiplier. One recoded multiplier digit is
//   retired per clock. The operands are signed or unsigned, selected per
//   operation. Operands and the product each move over a valid/ready
//   handshake.
//
//   Optional feature: define BOOTH_EARLY_TERM_EN to finish as soon as all
//   remaining multiplier digits are zero. Latency is then 1..ITER.
//   Without it, latency is fixed at ITER.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   operand handshake (a, b, signed_mode)
//   a, b                 multiplicand, multiplier (b is Booth-recoded)
//   signed_mode          1 = two's complement operands, 0 = unsigned
//   out_valid, out_ready product handshake
//   p                    2*WIDTH-bit product, held after the handshake
//   busy                 high whenever not IDLE
module booth_radix4_seq_mult #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int ITER = WIDTH / 2 + 1;
  localparam int ACCW = 2 * WIDTH + 4;
  // Multiplier shift register: WIDTH+2 extended bits plus the implicit b[-1].
  localparam int BW   = WIDTH + 3;
  localparam int CW   = $clog2(ITER);
  localparam logic [CW-1:0]   LAST = CW'(ITER - 1);
  localparam logic [ACCW-1:0] ONE  = ACCW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q;
  logic [ACCW-1:0]     acc_q, acc_d;
  logic [ACCW-1:0]     mcand_q;
  logic [ACCW-1:0]     pp_d;
  logic [BW-1:0]       mplr_q, mplr_d;
  logic [CW-1:0]       cnt_q;
  logic [2*WIDTH-1:0]  p_q;
  logic                in_ready_q, out_valid_q, busy_q;
  logic                last_d;
  logic                a_ext, b_ext;

  assign a_ext = signed_mode & a[WIDTH-1];
  assign b_ext = signed_mode & b[WIDTH-1];

  // The multiplicand is kept pre-shifted by 4^i. The multiplier is shifted
  // right arithmetically, so the current triplet is always mplr_q[2:0].
  always_comb begin
    pp_d = '0;
    unique case (mplr_q[2:0])
      3'b001, 3'b010: pp_d = mcand_q;
      3'b011:         pp_d = mcand_q << 1;
      3'b100:         pp_d = ~(mcand_q << 1) + ONE;
      3'b101, 3'b110: pp_d = ~mcand_q + ONE;
      default:        pp_d = '0;
    endcase
    acc_d  = acc_q + pp_d;
    mplr_d = {{2{mplr_q[BW-1]}}, mplr_q[BW-1:2]};
    last_d = (cnt_q == LAST);
`ifdef BOOTH_EARLY_TERM_EN
    // After the shift, bit 0 is b[2i+1]. Every bit above it is an unprocessed
    // multiplier bit or a copy of the sign. All equal means all remaining
    // digits recode to 0.
    if ((&mplr_d) || ~(|mplr_d)) last_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplr_q      <= '0;
      cnt_q       <= '0;
      p_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_q      <= '0;
            mcand_q    <= {{(ACCW-WIDTH){a_ext}}, a};
            mplr_q     <= {{2{b_ext}}, b, 1'b0};
            cnt_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_q << 2;
          mplr_q  <= mplr_d;
          cnt_q   <= cnt_q + CW'(1);
          if (last_d) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            p_q         <= acc_d[2*WIDTH-1:0];
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign p         = p_q;

endmodule
